// File: rtl/ddr3_test_pkg.sv
// ddr3_test_pkg
// Shared definitions for the DDR3 self-test traffic generator:
//   - ddr3_state_e : top-level test sequencer states
//   - ddr3_pattern : data pattern P(w) = SEED ^ w, optionally inverted
// The pattern function works on a wide fixed vector so callers of any data
// width up to PAT_MAX_W-1 bits take the low DATA_WIDTH bits of the result.
package ddr3_test_pkg;

  typedef enum logic [2:0] {
    WAIT_INIT = 3'd0,
    WRITE     = 3'd1,
    READ      = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4,
    ERROR     = 3'd5
  } ddr3_state_e;

  localparam int PAT_MAX_W = 1024;

  function automatic logic [PAT_MAX_W-1:0] ddr3_pattern(
    input logic [PAT_MAX_W-1:0] word,
    input logic [PAT_MAX_W-1:0] seed,
    input logic                 inv
  );
    return inv ? ~(seed ^ word) : (seed ^ word);
  endfunction

endpackage

// File: rtl/ddr3_readback_checker.sv
// ddr3_readback_checker
// Compares every returned read beat against the expected pattern word and
// keeps the error statistics.
//   clk, reset        : clock, asynchronous active-high reset
//   check_en          : a returned beat is legal now (READ/DRAIN with a burst outstanding)
//   inv               : pattern inversion latched at test start
//   rdata/rdata_valid : read data return from the controller
//   burst_done        : combinational, high on the last beat of a returned burst
//   proto_err         : sticky, a beat arrived while none was expected
//   error_count       : mismatching or stray beats, saturating
//   first_error_addr  : word address of the first data mismatch
import ddr3_test_pkg::*;

module ddr3_readback_checker #(
  parameter int          ADDR_WIDTH = 24,
  parameter int          DATA_WIDTH = 64,
  parameter int          BURST_LEN  = 4,
  parameter logic [63:0] SEED       = 64'hdeadfadebabebeef
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  check_en,
  input  logic                  inv,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rdata_valid,
  output logic                  burst_done,
  output logic                  proto_err,
  output logic [15:0]           error_count,
  output logic [ADDR_WIDTH-1:0] first_error_addr
);

  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic [ADDR_WIDTH-1:0] exp_idx;
  logic [BEAT_W-1:0]     ret_beat;
  logic                  first_seen;
  logic [PAT_MAX_W-1:0]  exp_full;
  logic [DATA_WIDTH-1:0] exp_pat;
  logic                  beat_ok;
  logic                  mismatch;
  logic                  stray;
  logic                  unused_exp_hi;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

  always_comb begin
    exp_full   = ddr3_pattern(PAT_MAX_W'(exp_idx), PAT_MAX_W'(SEED), inv);
    exp_pat    = exp_full[DATA_WIDTH-1:0];
    beat_ok    = rdata_valid && check_en;
    mismatch   = beat_ok && (rdata != exp_pat);
    stray      = rdata_valid && !check_en;
    burst_done = beat_ok && (ret_beat == LAST_BEAT);
  end

  assign unused_exp_hi = ^exp_full[PAT_MAX_W-1:DATA_WIDTH];

  // compare stage: statistics update on the edge that samples the beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_idx          <= '0;
      ret_beat         <= '0;
      first_seen       <= 1'b0;
      proto_err        <= 1'b0;
      error_count      <= '0;
      first_error_addr <= '0;
    end else begin
      if (beat_ok) begin
        exp_idx  <= exp_idx + ADDR_WIDTH'(1);
        ret_beat <= burst_done ? '0 : ret_beat + BEAT_W'(1);
      end
      if (mismatch || stray) error_count <= sat_inc(error_count);
      if (stray) proto_err <= 1'b1;
      // stray beats have no meaningful address, only data mismatches are captured
      if (mismatch && !first_seen) begin
        first_seen       <= 1'b1;
        first_error_addr <= exp_idx;
      end
    end
  end

endmodule

// File: rtl/ddr3_pattern_tester.sv
// ddr3_pattern_tester
// DDR3 bring-up traffic generator on the controller's Avalon-MM port.
// After calibration it writes P(w) over NUM_BURSTS*BURST_LEN words in bursts,
// reads them back with up to MAX_OUTSTANDING bursts in flight, checks every
// beat and reports pass/fail.
//   clk, reset                     : clock, asynchronous active-high reset
//   avl_*                          : Avalon-MM master towards the controller
//   ddr3_init_done/cal_success/fail: controller status
//   pattern_inv                    : selects inverted pattern, sampled leaving WAIT_INIT
//   is_finished, pass, fail        : sticky test status
//   error_count, first_error_addr  : checker statistics
import ddr3_test_pkg::*;

module ddr3_pattern_tester #(
  parameter int          ADDR_WIDTH      = 24,
  parameter int          DATA_WIDTH      = 64,
  parameter int          BURST_LEN       = 4,
  parameter int          NUM_BURSTS      = 1024,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [63:0] SEED            = 64'hdeadfadebabebeef
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    avl_ready,
  output logic                    avl_burstbegin,
  output logic [ADDR_WIDTH-1:0]   avl_addr,
  output logic [DATA_WIDTH-1:0]   avl_wdata,
  output logic [DATA_WIDTH/8-1:0] avl_be,
  output logic                    avl_read_req,
  output logic                    avl_write_req,
  output logic [6:0]              avl_size,
  input  logic [DATA_WIDTH-1:0]   avl_rdata,
  input  logic                    avl_rdata_valid,
  input  logic                    ddr3_init_done,
  input  logic                    ddr3_cal_success,
  input  logic                    ddr3_cal_fail,
  input  logic                    pattern_inv,
  output logic                    is_finished,
  output logic                    pass,
  output logic                    fail,
  output logic [15:0]             error_count,
  output logic [ADDR_WIDTH-1:0]   first_error_addr
);

  localparam int BEAT_W  = $clog2(BURST_LEN + 1);
  localparam int BURST_W = $clog2(NUM_BURSTS + 1);
  localparam int BE_W    = DATA_WIDTH / 8;
  localparam logic [BEAT_W-1:0]     LAST_BEAT    = BEAT_W'(BURST_LEN - 1);
  localparam logic [BURST_W-1:0]    LAST_BURST   = BURST_W'(NUM_BURSTS - 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_STRIDE = ADDR_WIDTH'(BURST_LEN);

  ddr3_state_e           state;
  logic                  inv_lat;
  logic [BEAT_W-1:0]     wr_beat;
  logic [BURST_W-1:0]    wr_burst;
  logic [BURST_W-1:0]    rd_burst;
  logic [ADDR_WIDTH-1:0] wr_word;
  logic [3:0]            outstanding;

  logic                  wr_accept;
  logic                  rd_accept;
  logic                  check_en;
  logic                  burst_done;
  logic                  proto_err;
  logic [4:0]            outs_next;
  logic                  issue_ok;
  logic [ADDR_WIDTH-1:0] wr_word_next;
  logic                  next_inv;
  logic [PAT_MAX_W-1:0]  next_pat_full;
  logic [DATA_WIDTH-1:0] next_pat;
  logic                  unused_pat_hi;

  always_comb begin
    wr_accept = avl_write_req && avl_ready;
    rd_accept = avl_read_req && avl_ready;
    check_en  = ((state == READ) || (state == DRAIN)) && (outstanding != 4'd0);
    outs_next = {1'b0, outstanding} + {4'b0, rd_accept} - {4'b0, burst_done};
    // decided from the count after this edge so the limit holds at acceptance
    issue_ok  = outs_next < 5'(MAX_OUTSTANDING);
    // word presented after this edge: 0 when entering WRITE, else the successor
    wr_word_next  = (state == WRITE) ? wr_word + ADDR_WIDTH'(1) : '0;
    next_inv      = (state == WAIT_INIT) ? pattern_inv : inv_lat;
    next_pat_full = ddr3_pattern(PAT_MAX_W'(wr_word_next), PAT_MAX_W'(SEED), next_inv);
    next_pat      = next_pat_full[DATA_WIDTH-1:0];
  end

  assign unused_pat_hi = ^next_pat_full[PAT_MAX_W-1:DATA_WIDTH];

  ddr3_readback_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_LEN  (BURST_LEN),
    .SEED       (SEED)
  ) u_checker (
    .clk              (clk),
    .reset            (reset),
    .check_en         (check_en),
    .inv              (inv_lat),
    .rdata            (avl_rdata),
    .rdata_valid      (avl_rdata_valid),
    .burst_done       (burst_done),
    .proto_err        (proto_err),
    .error_count      (error_count),
    .first_error_addr (first_error_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= WAIT_INIT;
      inv_lat        <= 1'b0;
      wr_beat        <= '0;
      wr_burst       <= '0;
      rd_burst       <= '0;
      wr_word        <= '0;
      outstanding    <= '0;
      avl_burstbegin <= 1'b0;
      avl_addr       <= '0;
      avl_wdata      <= '0;
      avl_be         <= '0;
      avl_read_req   <= 1'b0;
      avl_write_req  <= 1'b0;
      avl_size       <= '0;
      is_finished    <= 1'b0;
      pass           <= 1'b0;
      fail           <= 1'b0;
    end else begin
      avl_size    <= 7'(BURST_LEN);
      outstanding <= outs_next[3:0];
      case (state)
        WAIT_INIT: begin
          if (ddr3_init_done && ddr3_cal_success) begin
            state          <= WRITE;
            inv_lat        <= pattern_inv;
            wr_beat        <= '0;
            wr_burst       <= '0;
            wr_word        <= '0;
            avl_write_req  <= 1'b1;
            avl_burstbegin <= 1'b1;
            avl_addr       <= '0;
            avl_wdata      <= next_pat;
            avl_be         <= '1;
          end else if (ddr3_init_done && ddr3_cal_fail) begin
            state       <= ERROR;
            is_finished <= 1'b1;
            fail        <= 1'b1;
          end
        end
        WRITE: begin
          if (wr_accept) begin
            wr_word <= wr_word_next;
            if (wr_beat == LAST_BEAT) begin
              wr_beat <= '0;
              if (wr_burst == LAST_BURST) begin
                state          <= READ;
                avl_write_req  <= 1'b0;
                avl_read_req   <= 1'b1;
                avl_burstbegin <= 1'b1;
                avl_addr       <= '0;
                rd_burst       <= '0;
              end else begin
                wr_burst       <= wr_burst + BURST_W'(1);
                avl_burstbegin <= 1'b1;
                avl_addr       <= wr_word_next;
                avl_wdata      <= next_pat;
              end
            end else begin
              wr_beat        <= wr_beat + BEAT_W'(1);
              avl_burstbegin <= 1'b0;
              avl_wdata      <= next_pat;
            end
          end
        end
        READ: begin
          if (rd_accept) begin
            if (rd_burst == LAST_BURST) begin
              state          <= DRAIN;
              avl_read_req   <= 1'b0;
              avl_burstbegin <= 1'b0;
              avl_be         <= '0;
            end else begin
              rd_burst       <= rd_burst + BURST_W'(1);
              avl_addr       <= avl_addr + BURST_STRIDE;
              avl_read_req   <= issue_ok;
              avl_burstbegin <= issue_ok;
              avl_be         <= {BE_W{issue_ok}};
            end
          end else if (!avl_read_req) begin
            // an unaccepted request holds; an idle slot re-arms when a burst retires
            avl_read_req   <= issue_ok;
            avl_burstbegin <= issue_ok;
            avl_be         <= {BE_W{issue_ok}};
          end
        end
        DRAIN: begin
          // the final compare has already retired on the edge that emptied the count
          if (outstanding == 4'd0) begin
            state       <= DONE;
            is_finished <= 1'b1;
            if ((error_count == 16'd0) && !proto_err) pass <= 1'b1;
            else                                     fail <= 1'b1;
          end
        end
        DONE: begin
        end
        ERROR: begin
          is_finished <= 1'b1;
          fail        <= 1'b1;
        end
        default: begin
          state          <= ERROR;
          avl_read_req   <= 1'b0;
          avl_write_req  <= 1'b0;
          avl_burstbegin <= 1'b0;
          avl_be         <= '0;
          is_finished    <= 1'b1;
          fail           <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_pattern_tester.sv
// tb_ddr3_pattern_tester
// Directed bench for ddr3_pattern_tester with an Avalon memory model and a
// scoreboard of expected write beats and read-request addresses.
module tb_ddr3_pattern_tester;

  localparam int AW = 10, DW = 64, BL = 4, NB = 8, MAXO = 2, NW = NB * BL;
  localparam logic [63:0] SEED_TB = 64'hdeadfadebabebeef;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          avl_ready = 1'b1;
  logic          avl_burstbegin;
  logic [AW-1:0] avl_addr;
  logic [DW-1:0] avl_wdata;
  logic [7:0]    avl_be;
  logic          avl_read_req;
  logic          avl_write_req;
  logic [6:0]    avl_size;
  logic [DW-1:0] avl_rdata = '0;
  logic          avl_rdata_valid = 1'b0;
  logic          ddr3_init_done = 1'b0;
  logic          ddr3_cal_success = 1'b0;
  logic          ddr3_cal_fail = 1'b0;
  logic          pattern_inv = 1'b0;
  logic          is_finished, pass, fail;
  logic [15:0]   error_count;
  logic [AW-1:0] first_error_addr;

  ddr3_pattern_tester #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BURST_LEN (BL), .NUM_BURSTS (NB),
    .MAX_OUTSTANDING (MAXO), .SEED (SEED_TB)
  ) dut (
    .clk (clk), .reset (reset), .avl_ready (avl_ready),
    .avl_burstbegin (avl_burstbegin), .avl_addr (avl_addr), .avl_wdata (avl_wdata),
    .avl_be (avl_be), .avl_read_req (avl_read_req), .avl_write_req (avl_write_req),
    .avl_size (avl_size), .avl_rdata (avl_rdata), .avl_rdata_valid (avl_rdata_valid),
    .ddr3_init_done (ddr3_init_done), .ddr3_cal_success (ddr3_cal_success),
    .ddr3_cal_fail (ddr3_cal_fail), .pattern_inv (pattern_inv),
    .is_finished (is_finished), .pass (pass), .fail (fail),
    .error_count (error_count), .first_error_addr (first_error_addr)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, lat = 3, ready_mode = 0, fault_word = -1;
  logic [63:0] mem [0:31];
  logic [63:0] exp_wq[$];
  int exp_waq[$], exp_rq[$], pend_q[$], due_q[$];
  int wbase, wbeat, ret_base, ret_left, ret_beat, outs_m, max_outs, n_wr, n_rd, req_seen;
  logic stall_prev, s_wreq, s_rreq, s_bb;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_wq.delete(); exp_waq.delete(); exp_rq.delete(); pend_q.delete(); due_q.delete();
    wbase = 0; wbeat = 0; ret_base = 0; ret_left = 0; ret_beat = 0;
    outs_m = 0; max_outs = 0; n_wr = 0; n_rd = 0; req_seen = 0; stall_prev = 1'b0;
    avl_rdata_valid = 1'b0; avl_rdata = '0; avl_ready = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = '0;
  endtask

  task automatic prime(input logic inv);
    logic [63:0] p;
    for (int w = 0; w < NW; w++) begin
      p = SEED_TB ^ 64'(w);
      exp_wq.push_back(inv ? ~p : p);
    end
    for (int b = 0; b < NB; b++) begin
      exp_waq.push_back(b * BL);
      exp_rq.push_back(b * BL);
    end
  endtask

  // One clock of the memory model, evaluated at the falling edge for the
  // rising edge that follows.
  task automatic step();
    int idx;
    @(negedge clk);
    cyc++;
    avl_ready = (ready_mode != 0 && (cyc % 3) == 0) ? 1'b0 : 1'b1;
    if (stall_prev) begin
      chk("hold_wreq", avl_write_req, s_wreq);
      chk("hold_rreq", avl_read_req, s_rreq);
      chk("hold_bb", avl_burstbegin, s_bb);
      chk("hold_addr", avl_addr, s_addr);
      chk("hold_wdata", avl_wdata, s_wdata);
    end
    if (avl_write_req || avl_read_req) begin
      req_seen++;
      chk("be", avl_be, 8'hff);
    end
    if (avl_write_req && avl_ready) begin
      if (avl_burstbegin) begin
        wbase = avl_addr; wbeat = 0;
        if (exp_waq.size() != 0) chk("waddr", avl_addr, exp_waq.pop_front());
        else chk("extra_wburst", 1, 0);
      end
      mem[(wbase + wbeat) & 31] = avl_wdata;
      wbeat++; n_wr++;
      if (exp_wq.size() != 0) chk("wdata", avl_wdata, exp_wq.pop_front());
      else chk("extra_write", 1, 0);
    end
    if (avl_read_req && avl_ready) begin
      n_rd++;
      chk("rd_bb", avl_burstbegin, 1);
      if (exp_rq.size() != 0) chk("raddr", avl_addr, exp_rq.pop_front());
      else chk("extra_read", 1, 0);
      pend_q.push_back(int'(avl_addr));
      due_q.push_back(cyc + lat);
      outs_m++;
      if (outs_m > max_outs) max_outs = outs_m;
    end
    stall_prev = (avl_write_req || avl_read_req) && !avl_ready;
    s_wreq = avl_write_req; s_rreq = avl_read_req; s_bb = avl_burstbegin;
    s_addr = avl_addr; s_wdata = avl_wdata;
    if (ret_left == 0 && pend_q.size() != 0 && due_q[0] <= cyc) begin
      ret_base = pend_q.pop_front();
      void'(due_q.pop_front());
      ret_left = BL; ret_beat = 0;
    end
    if (ret_left > 0) begin
      idx = ret_base + ret_beat;
      avl_rdata = mem[idx & 31] ^ ((idx == fault_word) ? 64'd1 : 64'd0);
      avl_rdata_valid = 1'b1;
      ret_beat++; ret_left--;
      if (ret_left == 0) outs_m--;
    end else begin
      avl_rdata_valid = 1'b0;
      avl_rdata = '0;
    end
  endtask

  task automatic start_run(input logic inv, input int l, input int rm, input int fw);
    model_reset();
    prime(inv);
    lat = l; ready_mode = rm; fault_word = fw; pattern_inv = inv;
    ddr3_init_done = 1'b0; ddr3_cal_success = 1'b0; ddr3_cal_fail = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    ddr3_init_done = 1'b1; ddr3_cal_success = 1'b1;
  endtask

  task automatic run_test(input string name, input logic inv, input int l, input int rm,
                          input int fw, input logic exp_pass, input int exp_err);
    start_run(inv, l, rm, fw);
    for (int i = 0; i < 3000 && !is_finished; i++) step();
    chk({name, "_finished"}, is_finished, 1);
    step(); step();
    chk({name, "_nwr"}, n_wr, NW);
    chk({name, "_nrd"}, n_rd, NB);
    chk({name, "_wq_left"}, exp_wq.size(), 0);
    chk({name, "_max_outs"}, max_outs, MAXO);
    chk({name, "_pass"}, pass, exp_pass);
    chk({name, "_fail"}, fail, !exp_pass);
    chk({name, "_err_cnt"}, error_count, exp_err);
    if (fw >= 0) chk({name, "_first_addr"}, first_error_addr, fw);
  endtask

  initial begin
    model_reset();
    step(); step();
    chk("rst_wreq", avl_write_req, 0);
    chk("rst_rreq", avl_read_req, 0);
    chk("rst_size", avl_size, 0);
    chk("rst_fin", {is_finished, pass, fail}, 0);
    chk("rst_errcnt", error_count, 0);

    run_test("basic", 1'b0, 3, 0, -1, 1'b1, 0);
    run_test("bp", 1'b0, 3, 1, -1, 1'b1, 0);
    run_test("fault", 1'b0, 3, 0, 13, 1'b0, 1);
    run_test("lat10", 1'b0, 10, 0, -1, 1'b1, 0);

    // calibration failure: no traffic, error termination
    model_reset();
    ddr3_init_done = 1'b0; ddr3_cal_success = 1'b0; ddr3_cal_fail = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step(); step();
    chk("cal_wait_fin", is_finished, 0);
    ddr3_init_done = 1'b1; ddr3_cal_fail = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("cal_fin", is_finished, 1);
    chk("cal_fail", fail, 1);
    chk("cal_pass", pass, 0);
    chk("cal_no_req", req_seen, 0);

    // reset in the middle of the read phase, then an inverted-pattern rerun
    start_run(1'b0, 3, 0, -1);
    for (int i = 0; i < 200 && !avl_read_req; i++) step();
    chk("mid_in_read", avl_read_req, 1);
    step(); step(); step();
    reset = 1'b1;
    #1;
    chk("mid_rst_req", {avl_write_req, avl_read_req, avl_burstbegin}, 0);
    chk("mid_rst_addr", avl_addr, 0);
    chk("mid_rst_wdata", avl_wdata, 0);
    chk("mid_rst_be", avl_be, 0);
    chk("mid_rst_stat", {is_finished, pass, fail}, 0);
    chk("mid_rst_cnt", error_count, 0);
    chk("mid_rst_first", first_error_addr, 0);
    run_test("inv", 1'b1, 3, 0, -1, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_pattern_tester.md
# ddr3_pattern_tester

Parametrised DDR3 self-test traffic generator on the Avalon-MM port of the DDR3 controller in the memory bring-up test harness. After calibration it:
- writes a deterministic pattern over a configurable address range using multi-beat bursts;
- reads the range back with pipelined reads;
- checks every returned beat, counting mismatches and recording the first failing address.

It drives the board pass/fail indicators.

## Interface
- ADDR_WIDTH, 24: Avalon word-address width.
- DATA_WIDTH, 64: Avalon data width; a multiple of 8.
- BURST_LEN, 4: beats per burst, 1..64.
- NUM_BURSTS, 1024: bursts per pass; NUM_BURSTS*BURST_LEN <= 2**ADDR_WIDTH.
- MAX_OUTSTANDING, 4: read bursts in flight, 1..15.
- SEED, 64'hdeadfadebabebeef: pattern seed, truncated or zero-extended to DATA_WIDTH.
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- avl_ready  in  1  controller accepts the current request/beat.
- avl_burstbegin  out  1  first beat of a burst.
- avl_addr  out  ADDR_WIDTH  burst start address.
- avl_wdata  out  DATA_WIDTH  write beat data.
- avl_be  out  DATA_WIDTH/8  byte enables; all ones while any request is active.
- avl_read_req  out  1  read request.
- avl_write_req  out  1  write beat valid.
- avl_size  out  7  burst length; equals BURST_LEN.
- avl_rdata  in  DATA_WIDTH  read data.
- avl_rdata_valid  in  1  read beat valid.
- ddr3_init_done, ddr3_cal_success, ddr3_cal_fail  in  1 each  controller status.
- pattern_inv  in  1  selects the inverted pattern; sampled when leaving WAIT_INIT.
- is_finished, pass, fail  out  1 each  test status; sticky until reset.
- error_count  out  16  mismatching beats; saturates at 16'hffff.
- first_error_addr  out  ADDR_WIDTH  word address of the first mismatch.

## Operation
- All outputs are registered. At reset every output is 0 and the state is WAIT_INIT.
- Word index w = burst*BURST_LEN + beat; the word address is w.
- Pattern P(w) = SEED ^ zext(w); if pattern_inv is latched, P(w) = ~(SEED ^ zext(w)).
- WAIT_INIT: when ddr3_init_done and ddr3_cal_success, go to WRITE. When ddr3_init_done and ddr3_cal_fail (without success), go to ERROR.
- WRITE:
  - Present beats of burst b with avl_write_req=1 and avl_wdata=P(w).
  - On the first beat, avl_burstbegin=1 and avl_addr=b*BURST_LEN.
  - A beat is accepted on any cycle where avl_write_req && avl_ready. The next beat is presented the following cycle; otherwise all outputs hold.
  - After the last beat of the last burst, go to READ.
- READ:
  - Issue avl_read_req with avl_burstbegin=1 and avl_addr=b*BURST_LEN while the outstanding count < MAX_OUTSTANDING.
  - The request is accepted on avl_read_req && avl_ready.
  - Outstanding count: +1 on acceptance; -1 on the last beat of a returned burst. Both in the same cycle leave it unchanged.
  - After the last request is accepted, go to DRAIN.
- Checker (READ and DRAIN):
  - Each avl_rdata_valid beat is compared with P(expected word index); the expected index increments per beat, and returns are in order.
  - On a mismatch, error_count increments (saturating). On the first mismatch, first_error_addr captures the address.
- DRAIN: when the outstanding count reaches 0, go to DONE.
- DONE: is_finished=1. pass=1 if error_count==0, else fail=1.
- ERROR: is_finished=1 and fail=1.
- Protocol error: avl_rdata_valid with outstanding count 0, or outside READ/DRAIN. This increments error_count and forces fail=1 at finish.
- An illegal state encoding goes to ERROR.
- Reset asserted mid-test aborts immediately. All counters and outputs clear, and any request in flight is dropped.

## Timing
- Output changes appear one cycle after the qualifying input edge.
- Back-to-back accepted beats and requests run at 1 per cycle.
- Read-data compare is registered: error_count updates 1 cycle after the beat. DONE is entered only after the final compare has retired.
- Minimum test length: 2 + NUM_BURSTS*BURST_LEN write cycles + NUM_BURSTS read-issue cycles + read latency.

## Structure
- Package ddr3_test_pkg holds:
  - the state enum (WAIT_INIT, WRITE, READ, DRAIN, DONE, ERROR);
  - the pattern function P(w, seed, inv).
- Sub-module ddr3_readback_checker: owns the expected-index counter, comparator, error_count saturation and first_error_addr capture. It receives rdata, rdata_valid and inv, and the top instantiates it.

## Test plan
- Test configuration: BURST_LEN=4, NUM_BURSTS=8, memory model with 3-cycle read latency, avl_ready=1 always. Stimulus: cal_success. Required: 32 writes with avl_wdata=SEED^w, 8 reads, pass=1, error_count=0.
- Backpressure: avl_ready toggling 1-of-3. Required: outputs hold while avl_ready=0, no beats are lost, pass=1.
- Fault: the model flips bit 0 of word 13. Required: error_count=1, first_error_addr=13, fail=1.
- MAX_OUTSTANDING=2 with 10-cycle latency. Required: never more than 2 read requests accepted ahead of completion.
- Calibration failure: init_done=1 and cal_fail=1. Required: ERROR, fail=1, no avl request is ever asserted.
- Reset pulse during READ, then rerun with pattern_inv=1. Required: outputs clear to 0 within the reset, and the rerun writes ~(SEED^w) and passes.
